// File: rtl/risc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// risc_ctrl_seq : eight-phase control sequencer for the 8-bit accumulator CPU
// Revision 1.0  : initial release
// ============================================================================
module risc_ctrl_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic             halt,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] C_OP_HLT = 3'b000;
  localparam logic [2:0] C_OP_SKZ = 3'b001;
  localparam logic [2:0] C_OP_ADD = 3'b010;
  localparam logic [2:0] C_OP_AND = 3'b011;
  localparam logic [2:0] C_OP_XOR = 3'b100;
  localparam logic [2:0] C_OP_LDA = 3'b101;
  localparam logic [2:0] C_OP_STO = 3'b110;
  localparam logic [2:0] C_OP_JMP = 3'b111;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  phase_t           r_phase;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_phase_inc;
  logic             w_aluop;

  assign w_phase_inc = r_phase + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= INST_ADDR;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else if (ena && !r_halted) begin
      // HLT parks the sequencer in OP_ADDR; the instruction never retires
      if (r_phase == OP_ADDR && opcode == C_OP_HLT) begin
        r_halted <= 1'b1;
      end else begin
        r_phase <= phase_t'(w_phase_inc);
        if (r_phase == STORE && r_cnt != C_CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign w_aluop = (opcode == C_OP_ADD) || (opcode == C_OP_AND) ||
                   (opcode == C_OP_XOR) || (opcode == C_OP_LDA);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (r_halted) begin
      halt = 1'b1;
    end else begin
      case (r_phase)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == C_OP_HLT);
        end
        OP_FETCH: rd = w_aluop;
        ALU_OP: begin
          rd     = w_aluop;
          inc_pc = (opcode == C_OP_SKZ) && zero;
          ld_pc  = (opcode == C_OP_JMP);
          data_e = (opcode == C_OP_STO);
        end
        STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = (opcode == C_OP_JMP);
          wr     = (opcode == C_OP_STO);
          data_e = (opcode == C_OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign phase     = r_phase;
  assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_risc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// tb_risc_ctrl_seq : directed self-checking bench for risc_ctrl_seq
// Revision 1.0     : initial release
// ============================================================================
module tb_risc_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [2:0]  opcode;
  logic        zero;

  logic        sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0]  phase;
  logic [15:0] instr_cnt;

  logic        sel2, rd2, ld_ir2, inc_pc2, ld_pc2, ld_ac2, wr2, data_e2, halt2;
  logic [2:0]  phase2;
  logic [1:0]  instr_cnt2;

  logic [8:0]  strobes;
  int          errors = 0;
  int          checks = 0;

  // bit order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  always #5 clk = ~clk;

  risc_ctrl_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt),
    .phase(phase), .instr_cnt(instr_cnt)
  );

  risc_ctrl_seq #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .sel(sel2), .rd(rd2), .ld_ir(ld_ir2), .inc_pc(inc_pc2), .ld_pc(ld_pc2),
    .ld_ac(ld_ac2), .wr(wr2), .data_e(data_e2), .halt(halt2),
    .phase(phase2), .instr_cnt(instr_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction from phase 0; opcode/zero are scrambled during
  // fetch to show they only matter from phase 4 onward.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] exp_s [8];
    exp_s[0] = 9'b100000000;
    exp_s[1] = 9'b110000000;
    exp_s[2] = 9'b111000000;
    exp_s[3] = 9'b111000000;
    exp_s[4] = e4;
    exp_s[5] = e5;
    exp_s[6] = e6;
    exp_s[7] = e7;
    for (int p = 0; p < 8; p++) begin
      if (p < 4) begin
        opcode = 3'($urandom);
        zero   = 1'($urandom);
      end else begin
        opcode = op;
        zero   = z;
      end
      #1;
      chk($sformatf("%s_phase%0d", tag, p), 32'(phase), 32'(p));
      chk($sformatf("%s_strobes_p%0d", tag, p), 32'(strobes), 32'(exp_s[p]));
      step();
    end
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b0;
    opcode = 3'b010;
    zero   = 1'b0;
    #2;
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_strobes", 32'(strobes), 32'(9'b100000000));
    chk("reset_cnt", 32'(instr_cnt), 32'd0);
    chk("reset_cnt_sat", 32'(instr_cnt2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;

    // two ADDs
    run_instr("add0", 3'b010, 1'b0, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000);
    chk("cnt_after_add0", 32'(instr_cnt), 32'd1);
    run_instr("add1", 3'b010, 1'b1, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000);
    chk("cnt_after_add1", 32'(instr_cnt), 32'd2);

    run_instr("sto",  3'b110, 1'b0, 9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110);
    run_instr("skz1", 3'b001, 1'b1, 9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000);
    run_instr("skz0", 3'b001, 1'b0, 9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000);
    run_instr("jmp",  3'b111, 1'b0, 9'b000100000, 9'b000000000, 9'b000010000, 9'b000010000);
    run_instr("lda",  3'b101, 1'b0, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000);
    chk("cnt_after_7", 32'(instr_cnt), 32'd7);
    chk("cnt_sat_after_7", 32'(instr_cnt2), 32'd3);

    // stall in phase 5
    opcode = 3'b011;
    zero   = 1'b0;
    repeat (5) step();
    chk("stall_pre_phase", 32'(phase), 32'd5);
    chk("stall_pre_strobes", 32'(strobes), 32'(9'b010000000));
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_phase_%0d", i), 32'(phase), 32'd5);
      chk($sformatf("stall_strobes_%0d", i), 32'(strobes), 32'(9'b010000000));
    end
    ena = 1'b1;
    step();
    chk("resume_phase", 32'(phase), 32'd6);
    chk("resume_strobes", 32'(strobes), 32'(9'b010000000));
    step();
    chk("resume_p7_strobes", 32'(strobes), 32'(9'b010001000));
    step();
    chk("resume_wrap_phase", 32'(phase), 32'd0);
    chk("cnt_after_stall", 32'(instr_cnt), 32'd8);

    // asynchronous reset in the middle of phase 6
    repeat (6) step();
    chk("pre_rst_phase", 32'(phase), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_phase", 32'(phase), 32'd0);
    chk("async_rst_cnt", 32'(instr_cnt), 32'd0);
    chk("async_rst_strobes", 32'(strobes), 32'(9'b100000000));
    @(negedge clk);
    rst = 1'b0;

    // one ADD to retire, then HLT
    run_instr("pre_hlt", 3'b010, 1'b0, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000);
    chk("cnt_pre_hlt", 32'(instr_cnt), 32'd1);
    opcode = 3'b000;
    repeat (4) step();
    chk("hlt_p4_phase", 32'(phase), 32'd4);
    chk("hlt_p4_strobes", 32'(strobes), 32'(9'b000100001));
    step();
    opcode = 3'b010;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) ena = 1'b0;
      if (i == 13) ena = 1'b1;
      chk($sformatf("halted_phase_%0d", i), 32'(phase), 32'd4);
      chk($sformatf("halted_strobes_%0d", i), 32'(strobes), 32'(9'b000000001));
      step();
    end
    chk("halted_cnt", 32'(instr_cnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("hlt_rst_phase", 32'(phase), 32'd0);
    chk("hlt_rst_strobes", 32'(strobes), 32'(9'b100000000));
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_first_phase", 32'(phase), 32'd1);
    repeat (7) step();

    // saturation of the 2-bit counter over five instructions
    chk("sat_cnt_start", 32'(instr_cnt2), 32'd1);
    for (int n = 2; n <= 5; n++) begin
      run_instr($sformatf("sat_xor%0d", n), 3'b100, 1'b0,
                9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000);
      chk($sformatf("sat_cnt_%0d", n), 32'(instr_cnt2), 32'((n > 3) ? 3 : n));
      chk($sformatf("wide_cnt_%0d", n), 32'(instr_cnt), 32'(n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc_ctrl_seq.md
Name: risc_ctrl_seq

Overview:
- Eight-phase control sequencer for the 8-bit accumulator CPU.
- Every instruction takes 8 clock phases:
  - fetch: instruction address, fetch, IR load, idle;
  - execute: operand address, operand fetch, ALU op, store.
- Each phase drives the memory, PC, IR, accumulator and ALU-datapath enables, decoded from the 3-bit instruction opcode and the accumulator-zero flag.
- Sits between the instruction register and the datapath; HLT freezes the CPU until reset.

Parameters:
- CNT_W, 16, width of the retired-instruction counter (saturating).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- ena  input  1  phase-advance enable; 0 stalls the sequencer in its current phase
- opcode  input  3  IR[7:5]; 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP
- zero  input  1  accumulator-zero flag (ALU is_zero of accumulator)
- sel  output  1  address mux: 1 = PC, 0 = IR operand address
- rd  output  1  memory read strobe
- ld_ir  output  1  instruction register load
- inc_pc  output  1  program counter increment
- ld_pc  output  1  program counter load (jump)
- ld_ac  output  1  accumulator load from ALU out
- wr  output  1  memory write strobe
- data_e  output  1  accumulator drives data bus
- halt  output  1  CPU halted (sticky)
- phase  output  3  current phase index, 0..7
- instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- State:
  - 3-bit phase register, 0 INST_ADDR … 7 STORE;
  - halted flag;
  - instr_cnt register.
- Phase stepping:
  - ena=1 and not halted: phase advances by one per clk, 7 wraps to 0.
  - ena=0: phase and all outputs hold unchanged.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Outputs are combinational from phase/halted/opcode/zero. Any signal not listed for a phase is 0.
  - Phase 0: sel=1.
  - Phase 1: sel=1, rd=1.
  - Phases 2 and 3: sel=1, rd=1, ld_ir=1.
  - Phase 4: inc_pc=1; halt=1 if opcode=HLT.
  - Phase 5: rd=ALUOP.
  - Phase 6: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - Phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
- HLT:
  - On the clk edge leaving phase 4 with opcode=HLT (ena=1), set halted.
  - Phase freezes at 4.
  - While halted: halt=1, all other strobes 0, ena ignored, instr_cnt frozen.
  - Only rst clears halted.
- instr_cnt:
  - Increments on each 7→0 transition.
  - Saturates at 2^CNT_W-1, no wrap.
  - A halted instruction is not counted.
- opcode and zero are used only in phases 4–7; changes in phases 0–3 have no effect on outputs.
- Reset (asynchronous, any time including mid-instruction):
  - phase=0, halted=0, instr_cnt=0.
  - Outputs therefore read sel=1, all others 0, halt=0.
  - Release is synchronous to the next clk edge; the first advance is to phase 1.
- No stall-induced glitches: strobes change only after a clk edge or rst assertion.

Test Plan:
- Reset then ena=1, opcode=ADD, 16 clocks:
  - phase sequence 0..7,0..7;
  - rd high in phases 1,2,3,5,6,7;
  - ld_ac only in phase 7;
  - instr_cnt=2.
- opcode=STO, one instruction:
  - data_e=1 in phases 6,7; wr=1 only in phase 7;
  - rd=0 and ld_ac=0 in phases 5–7.
- opcode=SKZ:
  - with zero=1: inc_pc=1 in phases 4 and 6;
  - with zero=0: inc_pc only in phase 4.
- opcode=JMP: ld_pc=1 in phases 6,7; rd=0, ld_ac=0 in phases 5–7.
- opcode=HLT:
  - halt=1 in phase 4;
  - after the next edge, halt stays 1 and phase stays 4 for 20 clocks with all strobes 0;
  - instr_cnt unchanged;
  - rst pulse → phase=0, halt=0.
- Edge cases:
  - ena toggled 0 in phase 5 for 3 clocks → phase and outputs frozen, resume at 6.
  - rst asserted mid-phase 6 → immediate phase=0, instr_cnt=0.
  - CNT_W=2 run of 5 instructions → instr_cnt saturates at 3.
